// File: rtl/redstone_tick_gen_if.sv
// Bundle of the tick generator's control inputs, tick/settle handshake and status outputs.
// master = the tick generator, slave = the controller/simulation side driving it.
interface redstone_tick_gen_if #(
  parameter int CNT_W  = 32,
  parameter int TCNT_W = 16
);
  // Handshake: o_tick is a one-cycle strobe that hands a new game tick to the simulation;
  // i_done is a level the simulation holds high once it has settled after that tick. The
  // generator ignores i_done in the tick cycle itself and issues no further tick until
  // i_done has been seen high in SETTLE, so a tick is never lost and none is ever doubled.
  logic              i_run;
  logic              i_step_n;
  logic [CNT_W-1:0]  i_period;
  logic              i_done;
  logic              i_clr_ovr;
  logic              o_tick;
  logic [TCNT_W-1:0] o_tick_count;
  logic              o_busy;
  logic              o_overrun;
  logic [1:0]        state_dbg;

  modport master (
    input  i_run, i_step_n, i_period, i_done, i_clr_ovr,
    output o_tick, o_tick_count, o_busy, o_overrun, state_dbg
  );

  modport slave (
    output i_run, i_step_n, i_period, i_done, i_clr_ovr,
    input  o_tick, o_tick_count, o_busy, o_overrun, state_dbg
  );
endinterface

// File: rtl/redstone_tick_gen.sv
// Game-tick enable generator: free-run at a programmable period, debounced single-step,
// stop, and a settle handshake that holds off the next tick until the simulation is done.
module redstone_tick_gen #(
  parameter int CNT_W   = 32,
  parameter int TCNT_W  = 16,
  parameter int DEB_CYC = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_ar,
  redstone_tick_gen_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TICK   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  logic [1:0]        rst_sync;
  logic              rst_n;
  logic              run_m, run_s;
  logic              step_m, step_s;
  logic              deb_level;
  logic [DEB_W-1:0]  deb_cnt;
  logic              deb_hit;
  logic              press;
  logic              pending;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  per_m1;
  logic              expire;
  logic              run_req;
  logic              step_req;
  logic              tick_req;
  logic              ovr_set;
  state_t            state, state_nxt;
  logic [TCNT_W-1:0] tick_count;
  logic              overrun;

  // Reset asserts immediately with i_ar but is released only on a clock edge.
  always_ff @(posedge i_clk or negedge i_ar) begin
    if (!i_ar) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_m  <= 1'b0;
      run_s  <= 1'b0;
      step_m <= 1'b1;
      step_s <= 1'b1;
    end else begin
      run_m  <= bus.i_run;
      run_s  <= run_m;
      step_m <= bus.i_step_n;
      step_s <= step_m;
    end
  end

  // The accepted level flips on the DEB_CYC-th consecutive cycle of disagreement.
  assign deb_hit = (step_s != deb_level) && (deb_cnt == DEB_LAST);
  assign press   = deb_hit && !step_s;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_level <= 1'b1;
      deb_cnt   <= '0;
    end else if (step_s == deb_level) begin
      deb_cnt   <= '0;
    end else if (deb_hit) begin
      deb_level <= step_s;
      deb_cnt   <= '0;
    end else begin
      deb_cnt   <= deb_cnt + 1'b1;
    end
  end

  assign per_m1   = (bus.i_period == '0) ? '0 : bus.i_period - 1'b1;
  assign expire   = (cnt >= per_m1);
  assign run_req  = run_s && expire;
  assign step_req = !run_s && (pending || press);
  assign tick_req = run_req || step_req;

  // SETTLE may go straight to TICK once done, so the tightest loop is TICK+SETTLE.
  always_comb begin
    state_nxt = state;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (tick_req) state_nxt = TICK;
      end
      TICK: begin
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (bus.i_done) state_nxt = tick_req ? TICK : IDLE;
        else if (run_req) ovr_set = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Counter reads 0 during the tick cycle, so a tick is issued every max(period,2) cycles.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (state_nxt == TICK)  cnt <= '0;
    else if (cnt != '1)          cnt <= cnt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)                  pending <= 1'b0;
    else if (run_s)              pending <= 1'b0;
    else if (state_nxt == TICK)  pending <= 1'b0;
    else if (press)              pending <= 1'b1;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)              tick_count <= '0;
    else if (state == TICK)  tick_count <= tick_count + 1'b1;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)              overrun <= 1'b0;
    else if (ovr_set)        overrun <= 1'b1;
    else if (bus.i_clr_ovr)  overrun <= 1'b0;
  end

  assign bus.o_tick       = (state == TICK);
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_tick_count = tick_count;
  assign bus.o_overrun    = overrun;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_redstone_tick_gen.sv
// Directed bench for redstone_tick_gen: reset, free-run, debounced step, settle stall,
// overrun set/clear priority and tick counter wrap, with hand-computed expectations.
module tb_redstone_tick_gen;

  logic clk;
  logic ar;
  int   total;
  int   bad;
  int   ticks_done;
  int   b2b;
  logic prev_tick;
  logic [31:0] exp_q[$];

  redstone_tick_gen_if #(.CNT_W(32), .TCNT_W(4)) bus ();

  redstone_tick_gen #(.CNT_W(32), .TCNT_W(4), .DEB_CYC(4)) dut (
    .i_clk (clk),
    .i_ar  (ar),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference tick counter and back-to-back detector, sampled on the inactive edge.
  initial begin
    ticks_done = 0;
    b2b        = 0;
    prev_tick  = 1'b0;
  end
  always @(negedge clk) begin
    if (!ar) ticks_done <= 0;
    else if (bus.o_tick) ticks_done <= ticks_done + 1;
    prev_tick <= bus.o_tick;
    if (bus.o_tick && prev_tick) b2b <= b2b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns negedges until the next o_tick (bounded).
  task automatic wait_next_tick(output int d);
    d = 0;
    do begin
      @(negedge clk);
      d++;
    end while (!bus.o_tick && d < 200);
    if (!bus.o_tick) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_gap(input string tag, input int exp);
    int d;
    exp_q.push_back(32'(exp));
    wait_next_tick(d);
    chk(tag, 32'(d), exp_q.pop_front());
  endtask

  task automatic press(input int low_cyc, input int high_cyc);
    bus.i_step_n = 1'b0;
    repeat (low_cyc) @(negedge clk);
    bus.i_step_n = 1'b1;
    repeat (high_cyc) @(negedge clk);
  endtask

  initial begin
    int d;
    int n0;
    int guard;
    total = 0;
    bad   = 0;
    ar            = 1'b0;
    bus.i_run     = 1'b0;
    bus.i_step_n  = 1'b1;
    bus.i_period  = 32'd10;
    bus.i_done    = 1'b1;
    bus.i_clr_ovr = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tick",  32'(bus.o_tick), 32'd0);
    chk("rst_count", 32'(bus.o_tick_count), 32'd0);
    chk("rst_busy",  32'(bus.o_busy), 32'd0);
    chk("rst_ovr",   32'(bus.o_overrun), 32'd0);
    chk("rst_state", 32'(bus.state_dbg), 32'd0);
    ar = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_tick", 32'(ticks_done), 32'd0);

    // T2 free-run, period 10
    bus.i_run = 1'b1;
    wait_next_tick(d);
    repeat (30) @(negedge clk);
    chk("t2_count30", 32'(bus.o_tick_count), 32'd3);
    chk("t2_tick30",  32'(bus.o_tick), 32'd1);
    check_gap("t2_gap10", 10);
    bus.i_period = 32'd1;
    check_gap("t2_gap_p1a", 2);
    check_gap("t2_gap_p1b", 2);
    bus.i_period = 32'd0;
    check_gap("t2_gap_p0a", 2);
    check_gap("t2_gap_p0b", 2);
    // lowering the period below the running count expires at once
    bus.i_period = 32'd50;
    n0 = ticks_done;
    repeat (20) @(negedge clk);
    chk("t2_no_early", 32'(ticks_done - n0), 32'd1);
    bus.i_period = 32'd5;
    check_gap("t2_lower", 1);

    // T3 step with bounce
    bus.i_run    = 1'b0;
    bus.i_period = 32'd10;
    repeat (20) @(negedge clk);
    n0 = ticks_done;
    press(2, 6);
    chk("t3_glitch", 32'(ticks_done - n0), 32'd0);
    bus.i_step_n = 1'b0;
    wait_next_tick(d);
    chk("t3_step_lat", 32'(d), 32'd6);
    repeat (4) @(negedge clk);
    bus.i_step_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t3_one_tick", 32'(ticks_done - n0), 32'd1);
    chk("t3_count1", 32'(bus.o_tick_count), 32'((n0 + 1) % 16));
    press(10, 10);
    chk("t3_two_ticks", 32'(ticks_done - n0), 32'd2);
    chk("t3_count2", 32'(bus.o_tick_count), 32'((n0 + 2) % 16));

    // T1 reset mid-SETTLE with count=5
    guard = 0;
    while ((ticks_done % 16) != 4 && guard < 20) begin
      press(8, 8);
      guard++;
    end
    bus.i_done = 1'b0;
    press(8, 8);
    chk("t1_count5", 32'(bus.o_tick_count), 32'd5);
    chk("t1_busy",   32'(bus.o_busy), 32'd1);
    chk("t1_settle", 32'(bus.state_dbg), 32'd2);
    ar = 1'b0;
    #1;
    chk("t1_async_count", 32'(bus.o_tick_count), 32'd0);
    chk("t1_async_busy",  32'(bus.o_busy), 32'd0);
    chk("t1_async_tick",  32'(bus.o_tick), 32'd0);
    repeat (3) @(negedge clk);
    ar = 1'b1;
    bus.i_done = 1'b1;
    repeat (20) @(negedge clk);
    chk("t1_no_tick", 32'(ticks_done), 32'd0);
    chk("t1_count0",  32'(bus.o_tick_count), 32'd0);

    // T4 settle stall
    bus.i_period = 32'd4;
    bus.i_run    = 1'b1;
    wait_next_tick(d);
    bus.i_done = 1'b0;
    n0 = ticks_done;
    d  = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_busy) d++;
    end
    chk("t4_busy12", 32'(d), 32'd12);
    chk("t4_ovr", 32'(bus.o_overrun), 32'd1);
    chk("t4_no_extra", 32'(ticks_done - n0), 32'd1);
    bus.i_done = 1'b1;
    check_gap("t4_deferred", 1);
    check_gap("t4_no_backlog", 4);

    // T5 clear vs set
    @(negedge clk);
    bus.i_clr_ovr = 1'b1;
    @(negedge clk);
    bus.i_clr_ovr = 1'b0;
    chk("t5_pre_clear", 32'(bus.o_overrun), 32'd0);
    wait_next_tick(d);
    bus.i_done = 1'b0;
    repeat (3) @(negedge clk);
    bus.i_clr_ovr = 1'b1;
    @(negedge clk);
    bus.i_clr_ovr = 1'b0;
    chk("t5_set_wins", 32'(bus.o_overrun), 32'd1);
    bus.i_done = 1'b1;
    wait_next_tick(d);
    @(negedge clk);
    bus.i_clr_ovr = 1'b1;
    @(negedge clk);
    bus.i_clr_ovr = 1'b0;
    chk("t5_lone_clear", 32'(bus.o_overrun), 32'd0);

    // T6 counter wrap, then stop mid-SETTLE
    bus.i_period = 32'd2;
    guard = 0;
    do begin
      wait_next_tick(d);
      guard++;
    end while ((ticks_done % 16) != 15 && guard < 40);
    chk("t6_count15", 32'(bus.o_tick_count), 32'd15);
    @(negedge clk);
    chk("t6_wrap0", 32'(bus.o_tick_count), 32'd0);
    wait_next_tick(d);
    bus.i_done = 1'b0;
    @(negedge clk);
    bus.i_run = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_still_busy", 32'(bus.o_busy), 32'd1);
    bus.i_done = 1'b1;
    n0 = ticks_done;
    repeat (30) @(negedge clk);
    chk("t6_stopped", 32'(ticks_done - n0), 32'd0);
    chk("t6_idle", 32'(bus.o_busy), 32'd0);

    chk("no_back2back", 32'(b2b), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
